// File: rtl/punct_code.sv
// ---------------------------------------------------------------------------
// punct_code -- 802.11a rate-dependent puncturer
//
// Takes the {A,B} coded pairs from the rate-1/2 convolutional encoder,
// deletes bits according to the 802.11a puncturing pattern for rate 1/2,
// 2/3 or 3/4, and serialises the surviving bits one per cycle toward the
// interleaver. A 3-bit FIFO plus a ready handshake absorbs the
// 2-bits-in / 1-bit-out rate mismatch.
//
// Ports:
//   sys_clk        in   1  clock, all state on the rising edge
//   sys_rst        in   1  synchronous active-high reset
//   rate_sel       in   2  00=1/2, 01=2/3, 10=3/4, 11=reserved (as 1/2);
//                          sampled only on an accepted frame_start_i pair
//   frame_start_i  in   1  the pair on data_in is the first of a frame
//   data_in        in   2  coded pair, [1]=A (g0=133o), [0]=B (g1=171o)
//   data_valid_i   in   1  data_in valid
//   data_ready_o   out  1  a pair can be accepted this cycle
//   data_out       out  1  serial punctured bit (FIFO head)
//   data_valid_o   out  1  data_out valid (downstream always accepts)
// ---------------------------------------------------------------------------
module punct_code (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] rate_sel,
    input  logic       frame_start_i,
    input  logic [1:0] data_in,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       data_out,
    output logic       data_valid_o
);

    localparam logic [1:0] RATE_23 = 2'b01;
    localparam logic [1:0] RATE_34 = 2'b10;

    // Puncturing period in pairs; rate 1/2 and the reserved code use 1.
    function automatic logic [1:0] period_of(input logic [1:0] rate);
        case (rate)
            RATE_23: return 2'd2;
            RATE_34: return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    // Returns {keep_A, keep_B} for a pair at the given rate and phase.
    function automatic logic [1:0] keep_mask(input logic [1:0] rate,
                                             input logic [1:0] phase);
        case (rate)
            RATE_23: return (phase == 2'd0) ? 2'b11 : 2'b10;
            RATE_34: begin
                case (phase)
                    2'd0:    return 2'b11;
                    2'd1:    return 2'b10;
                    default: return 2'b01;
                endcase
            end
            default: return 2'b11;
        endcase
    endfunction

    logic [2:0] r_buf;      // r_buf[0] is the head bit
    logic [1:0] r_cnt;
    logic [1:0] r_phase;
    logic [1:0] r_rate_q;

    logic       w_accept;
    logic [1:0] w_rate_eff;
    logic [1:0] w_phase_eff;
    logic [1:0] w_phase_inc;
    logic [1:0] w_phase_nxt;
    logic [1:0] w_mask;
    logic       w_k0;
    logic       w_k1;
    logic [1:0] w_nkept;

    assign data_ready_o = (r_cnt <= 2'd1) && !sys_rst;
    assign data_valid_o = (r_cnt != 2'd0);
    assign data_out     = r_buf[0];

    assign w_accept = data_valid_i && data_ready_o;

    // A frame-start pair always uses phase 0 and the freshly offered rate.
    assign w_rate_eff  = frame_start_i ? rate_sel : r_rate_q;
    assign w_phase_eff = frame_start_i ? 2'd0     : r_phase;
    assign w_phase_inc = w_phase_eff + 2'd1;
    assign w_phase_nxt = (w_phase_inc >= period_of(w_rate_eff)) ? 2'd0 : w_phase_inc;

    assign w_mask = keep_mask(w_rate_eff, w_phase_eff);

    // Compact the surviving bits so the first kept bit is always w_k0.
    always_comb begin
        w_k0    = 1'b0;
        w_k1    = 1'b0;
        w_nkept = 2'd0;
        case (w_mask)
            2'b11: begin
                w_k0    = data_in[1];
                w_k1    = data_in[0];
                w_nkept = 2'd2;
            end
            2'b10: begin
                w_k0    = data_in[1];
                w_nkept = 2'd1;
            end
            2'b01: begin
                w_k0    = data_in[0];
                w_nkept = 2'd1;
            end
            default: begin
                w_k0    = 1'b0;
                w_k1    = 1'b0;
                w_nkept = 2'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_buf    <= 3'b000;
            r_cnt    <= 2'd0;
            r_phase  <= 2'd0;
            r_rate_q <= 2'b00;
        end else if (w_accept) begin
            // Accepts only happen with cnt <= 1, and the head leaves this
            // same edge, so nothing older remains: new bits land at the head.
            r_buf   <= {1'b0, w_k1, w_k0};
            r_cnt   <= w_nkept;
            r_phase <= w_phase_nxt;
            if (frame_start_i) begin
                r_rate_q <= rate_sel;
            end
        end else if (r_cnt != 2'd0) begin
            r_buf <= {1'b0, r_buf[2:1]};
            r_cnt <= r_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_punct_code.sv
module tb_punct_code;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] rate_sel;
    logic       frame_start_i;
    logic [1:0] data_in;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       data_out;
    logic       data_valid_o;

    punct_code dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rate_sel     (rate_sel),
        .frame_start_i(frame_start_i),
        .data_in      (data_in),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_out     (data_out),
        .data_valid_o (data_valid_o)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   max_cnt = 0;
    logic got_q[$];
    int   got_t[$];
    logic exp_q[$];
    logic rdy_log[$];

    // reference model state
    logic [1:0] m_rate;
    int         m_phase;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (data_valid_o === 1'b1) begin
            got_q.push_back(data_out);
            got_t.push_back(cyc);
        end
        if (int'(dut.r_cnt) > max_cnt) max_cnt = int'(dut.r_cnt);
    end

    task automatic model_pair(input logic fs, input logic [1:0] rs, input logic [1:0] pr);
        if (fs) begin
            m_rate  = (rs == 2'b11) ? 2'b00 : rs;
            m_phase = 0;
        end
        case (m_rate)
            2'b01: begin
                exp_q.push_back(pr[1]);
                if (m_phase == 0) exp_q.push_back(pr[0]);
                m_phase = (m_phase + 1) % 2;
            end
            2'b10: begin
                if (m_phase != 2) exp_q.push_back(pr[1]);
                if (m_phase != 1) exp_q.push_back(pr[0]);
                m_phase = (m_phase + 1) % 3;
            end
            default: begin
                exp_q.push_back(pr[1]);
                exp_q.push_back(pr[0]);
            end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_pair(input logic fs, input logic [1:0] rs, input logic [1:0] pr);
        int   w;
        logic acc;
        frame_start_i = fs;
        rate_sel      = rs;
        data_in       = pr;
        data_valid_i  = 1'b1;
        w   = 0;
        acc = 1'b0;
        forever begin
            acc = data_ready_o;
            rdy_log.push_back(acc);
            @(posedge sys_clk);
            #1;
            if (acc) break;
            w++;
            if (w > 20) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        if (acc) model_pair(fs, rs, pr);
    endtask

    task automatic idle(input int n);
        data_valid_i  = 1'b0;
        frame_start_i = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        rdy_log.delete();
    endtask

    // exp holds the expected bits MSB-first in its low n bits.
    task automatic check_stream(input string tag, input logic [15:0] exp, input int n);
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk({tag, "_bit"}, got_q[i], exp[n-1-i]);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_bit"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        logic [4:0] rdy_vec;
        sys_rst       = 1'b1;
        rate_sel      = 2'b00;
        frame_start_i = 1'b0;
        data_in       = 2'b00;
        data_valid_i  = 1'b0;
        m_rate        = 2'b00;
        m_phase       = 0;

        // reset state
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("rst_ready_low", data_ready_o, 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_out", data_out, 0);
        chk("rst_ready", data_ready_o, 1);
        @(posedge sys_clk);
        #1;

        // rate 1/2, valid held high
        clear_logs();
        send_pair(1'b1, 2'b00, 2'b10);
        send_pair(1'b0, 2'b00, 2'b01);
        send_pair(1'b0, 2'b00, 2'b11);
        idle(6);
        check_stream("r12", 16'b100111, 6);
        if (got_t.size() == 6) chk("r12_consecutive", got_t[5] - got_t[0], 5);
        else chk("r12_consecutive_n", got_t.size(), 6);
        rdy_vec = 5'b0;
        for (int i = 0; i < 5 && i < rdy_log.size(); i++) rdy_vec[4-i] = rdy_log[i];
        chk("r12_ready_pattern", rdy_vec, 5'b10101);
        chk("r12_ready_len", rdy_log.size(), 5);

        // rate 2/3: B of every second pair deleted
        clear_logs();
        send_pair(1'b1, 2'b01, 2'b11);
        send_pair(1'b0, 2'b01, 2'b01);
        send_pair(1'b0, 2'b01, 2'b10);
        send_pair(1'b0, 2'b01, 2'b11);
        idle(6);
        check_stream("r23", 16'b110101, 6);

        // rate 3/4
        clear_logs();
        send_pair(1'b1, 2'b10, 2'b10);
        send_pair(1'b0, 2'b10, 2'b11);
        send_pair(1'b0, 2'b10, 2'b01);
        send_pair(1'b0, 2'b10, 2'b10);
        send_pair(1'b0, 2'b10, 2'b00);
        send_pair(1'b0, 2'b10, 2'b11);
        idle(6);
        check_stream("r34", 16'b10111001, 8);

        // rate_sel change without frame_start is ignored
        clear_logs();
        send_pair(1'b1, 2'b10, 2'b11);
        send_pair(1'b0, 2'b00, 2'b01);
        send_pair(1'b0, 2'b00, 2'b10);
        send_pair(1'b0, 2'b00, 2'b11);
        idle(6);
        check_stream("midchange", 16'b110011, 6);

        // new frame at 1/2 while the previous frame still has bits queued
        clear_logs();
        send_pair(1'b1, 2'b10, 2'b11);
        send_pair(1'b1, 2'b00, 2'b01);
        send_pair(1'b0, 2'b00, 2'b10);
        idle(6);
        check_stream("newframe", 16'b110110, 6);

        // reserved rate code behaves as 1/2
        clear_logs();
        send_pair(1'b1, 2'b11, 2'b01);
        send_pair(1'b0, 2'b11, 2'b10);
        idle(6);
        check_stream("r_resv", 16'b0110, 4);

        // reset mid-stream with two bits buffered
        clear_logs();
        send_pair(1'b1, 2'b00, 2'b11);
        sys_rst      = 1'b1;
        data_valid_i = 1'b0;
        @(negedge sys_clk);
        chk("midrst_ready_low0", data_ready_o, 0);
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("midrst_ready_low1", data_ready_o, 0);
        chk("midrst_valid_in_rst", data_valid_o, 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("midrst_valid", data_valid_o, 0);
        chk("midrst_ready", data_ready_o, 1);
        chk("midrst_out", data_out, 0);
        @(posedge sys_clk);
        #1;
        idle(4);
        chk("midrst_bits", got_q.size(), 1);
        if (got_q.size() > 0) chk("midrst_first_bit", got_q[0], 1);

        // random gaps at each rate against the reference model
        for (int r = 0; r < 4; r++) begin
            clear_logs();
            for (int i = 0; i < 14; i++) begin
                logic       fs;
                logic [1:0] rs;
                fs = (i == 0) || (i == 8);
                rs = fs ? 2'(r) : 2'($urandom_range(0, 3));
                send_pair(fs, rs, 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
            idle(6);
            check_model($sformatf("rand_r%0d", r));
        end

        chk("cnt_max_le2", (max_cnt <= 2) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
